// File: rtl/argmax_pkg.sv
// Shared types and compare helper for the argmax blocks.
// Define ARGMAX_SIGNED_EN for a two's-complement compare; it is unsigned otherwise.
package argmax_pkg;

    localparam int N_DEF = 10;
    localparam int W_DEF = 8;
    localparam int GT_W  = 32;   // widest sample gt() accepts

    typedef enum logic {COLLECT, HOLD} argmax_state_t;

    // a > b for w-bit samples that are zero-extended into GT_W bits.
    function automatic logic gt(input logic [GT_W-1:0] a,
                                input logic [GT_W-1:0] b,
                                input int unsigned     w);
        logic [GT_W-1:0] mask;
        logic [GT_W-1:0] bias;
        mask = (GT_W'(1) << w) - GT_W'(1);
`ifdef ARGMAX_SIGNED_EN
        // Flipping the sign bit maps two's complement onto offset binary,
        // where an unsigned compare gives the signed order.
        bias = GT_W'(1) << (w - 1);
`else
        bias = '0;
`endif
        return ((a & mask) ^ bias) > ((b & mask) ^ bias);
    endfunction

endpackage

// File: rtl/argmax_cmp_stage.sv
// Running-best register: it keeps the best value and index seen so far and
// shows the candidate next best on its outputs. Ties keep the older, lower index.
module argmax_cmp_stage
    import argmax_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int IW = $clog2(N_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          first,
    input  logic [W-1:0]  in_data,
    input  logic [IW-1:0] idx,
    output logic [W-1:0]  next_val,
    output logic [IW-1:0] next_idx
);

    logic [W-1:0]  best_val;
    logic [IW-1:0] best_idx;
    logic          take;

    assign take     = first || gt(GT_W'(in_data), GT_W'(best_val), W);
    assign next_val = take ? in_data : best_val;
    assign next_idx = take ? idx     : best_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_val <= '0;
            best_idx <= '0;
        end else if (en) begin
            best_val <= next_val;
            best_idx <= next_idx;
        end
    end

endmodule

// File: rtl/stream_argmax.sv
// Streaming argmax over frames of N samples, with valid/ready in and out.
// Build with ARGMAX_SIGNED_EN for signed samples.
module stream_argmax
    import argmax_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] ind_max,
    output logic [W-1:0]  max_num,
    output logic [IW-1:0] frame_cnt
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    argmax_state_t state;
    logic          in_xfer;
    logic          out_xfer;
    logic [W-1:0]  next_val;
    logic [IW-1:0] next_idx;

    assign in_ready = (state == COLLECT);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    argmax_cmp_stage #(.W(W), .IW(IW)) u_cmp (
        .clk      (clk),
        .rst      (rst),
        .en       (in_xfer),
        .first    (frame_cnt == '0),
        .in_data  (in_data),
        .idx      (frame_cnt),
        .next_val (next_val),
        .next_idx (next_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            frame_cnt <= '0;
            out_valid <= 1'b0;
            ind_max   <= '0;
            max_num   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_xfer) begin
                        if (frame_cnt == LAST_IDX) begin
                            // The result includes the last sample, so take the candidate directly.
                            frame_cnt <= '0;
                            ind_max   <= next_idx;
                            max_num   <= next_val;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_xfer) begin
                        out_valid <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_argmax.sv
// Directed bench for stream_argmax: a table of frames plus hand-written
// sequences for backpressure, reset and back-to-back frames.
module tb_stream_argmax;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] ind_max;
    logic [7:0] max_num;
    logic [3:0] frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [0:9][7:0] smp;
        logic            gap;
        logic [3:0]      idx;
        logic [7:0]      val;
    } vec_t;

    vec_t vecs [4];

    stream_argmax dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ind_max   (ind_max),
        .max_num   (max_num),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offer the frame one sample per transfer; with gap set, an idle cycle precedes samples 1..9.
    task automatic feed(input logic [0:9][7:0] s, input logic gap);
        for (int k = 0; k < 10; k++) begin
            if (gap && k > 0) begin
                in_valid = 1'b0;
                tick();
                chk("gap_frame_cnt", 32'(frame_cnt), 32'(k));
            end
            in_valid = 1'b1;
            in_data  = s[k];
            if (k == 9) chk("pre_last_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [3:0] idx, input logic [7:0] val);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_ind_max"},   32'(ind_max),   32'(idx));
        chk({tag, "_max_num"},   32'(max_num),   32'(val));
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        logic [0:9][7:0] bp_frame;
        logic [0:9][7:0] rst_frame;
        logic [0:9][7:0] tie_frame;
        logic [3:0] bp_idx;
        logic [7:0] bp_val;
        logic [3:0] rs_idx;
        logic [7:0] rs_val;

        bp_frame  = {8'hB5, 8'h8D, 8'h4D, 8'h0F, 8'h8E, 8'h4A, 8'h03, 8'h9E, 8'h66, 8'h6D};
        rst_frame = {8'h05, 8'h8B, 8'hC1, 8'h18, 8'h16, 8'h4D, 8'h61, 8'h99, 8'h8B, 8'h49};
        tie_frame = {8'h01, 8'h0C, 8'h0A, 8'h0D, 8'h0D, 8'h0A, 8'h05, 8'h04, 8'h03, 8'h0B};
`ifdef ARGMAX_SIGNED_EN
        vecs[0] = '{smp: {8'h01, 8'h8F, 8'h49, 8'h09, 8'h8F, 8'h49, 8'hF1, 8'h9F, 8'h69, 8'h4D},
                    gap: 1'b0, idx: 4'd8, val: 8'h69};
        bp_idx = 4'd9; bp_val = 8'h6D;
        rs_idx = 4'd6; rs_val = 8'h61;
`else
        vecs[0] = '{smp: {8'h01, 8'h8F, 8'h49, 8'h09, 8'h8F, 8'h49, 8'hF1, 8'h9F, 8'h69, 8'h4D},
                    gap: 1'b0, idx: 4'd6, val: 8'hF1};
        bp_idx = 4'd0; bp_val = 8'hB5;
        rs_idx = 4'd2; rs_val = 8'hC1;
`endif
        vecs[1] = '{smp: tie_frame, gap: 1'b0, idx: 4'd3, val: 8'h0D};
        vecs[2] = '{smp: {8'h01, 8'h0C, 8'h0A, 8'h0D, 8'h0D, 8'h0A, 8'h05, 8'h04, 8'h03, 8'h4D},
                    gap: 1'b0, idx: 4'd9, val: 8'h4D};
        vecs[3] = '{smp: bp_frame, gap: 1'b1, idx: bp_idx, val: bp_val};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ind_max",   32'(ind_max),   32'd0);
        chk("rst_max_num",   32'(max_num),   32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Table: each result appears one cycle after the 10th sample and is taken at once.
        for (int v = 0; v < 4; v++) begin
            feed(vecs[v].smp, vecs[v].gap);
            chk_result($sformatf("vec%0d", v), vecs[v].idx, vecs[v].val);
            tick();
            chk($sformatf("vec%0d_out_drop", v), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d_ready_back", v), 32'(in_ready), 32'd1);
            chk($sformatf("vec%0d_hold_ind", v), 32'(ind_max), 32'(vecs[v].idx));
        end

        // Backpressure: result held, offered samples are not consumed.
        out_ready = 1'b0;
        feed(bp_frame, 1'b0);
        in_valid = 1'b1; in_data = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            chk_result($sformatf("bp%0d", c), bp_idx, bp_val);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_out_drop", 32'(out_valid), 32'd0);
        chk("bp_ready", 32'(in_ready), 32'd1);
        feed(tie_frame, 1'b0);
        chk_result("bp_next", 4'd3, 8'h0D);
        tick();

        // Reset mid-frame: the early FF must not carry over.
        feed_partial();
        chk("part_frame_cnt", 32'(frame_cnt), 32'd4);
        #2 rst = 1'b1;
        #1 chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        feed(rst_frame, 1'b0);
        chk_result("afterrst", rs_idx, rs_val);

        // Reset while a result is pending clears out_valid immediately.
        out_ready = 1'b0;
        tick();
        chk("pend_out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1 chk("asyncrst_out_valid", 32'(out_valid), 32'd0);
        chk("asyncrst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Back-to-back: a single HOLD cycle stalls the next frame's first sample.
        feed(vecs[0].smp, 1'b0);
        chk_result("b2b_a", vecs[0].idx, vecs[0].val);
        in_valid = 1'b1; in_data = 8'h01;
        tick();
        chk("b2b_stall_ready", 32'(in_ready), 32'd1);
        chk("b2b_stall_cnt",   32'(frame_cnt), 32'd0);
        chk("b2b_out_drop",    32'(out_valid), 32'd0);
        feed(vecs[2].smp, 1'b0);
        chk_result("b2b_b", vecs[2].idx, vecs[2].val);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    task automatic feed_partial();
        logic [0:3][7:0] p;
        p = {8'h10, 8'hFF, 8'h20, 8'h30};
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = p[k];
            tick();
        end
        in_valid = 1'b0;
    endtask

endmodule
